// File: rtl/ctrl_seq.sv
// Instruction sequencer for the 8-bit ALU: fetch/decode/execute control, PC, IR,
// 8x8 register file and cf/zf flags, plus load/store and conditional jump handling.
module ctrl_seq #(
  parameter int             PAW    = 8,
  parameter logic [PAW-1:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [PAW-1:0] pa,
  input  logic [15:0]    pd,
  output logic [15:0]    k,
  output logic [7:0]     x,
  output logic [7:0]     y,
  output logic           cf,
  input  logic [7:0]     q,
  input  logic           cl,
  input  logic           zl,
  output logic [7:0]     da,
  input  logic [7:0]     dm,
  output logic [7:0]     dw,
  output logic           we,
  output logic           halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [PAW-1:0] pc_q;
  logic [15:0]    ir_q;
  logic [7:0]     rf [8];
  logic           cf_q, zf_q;

  logic           rf_we, cf_upd, zf_upd, pc_jump, take;
  logic [2:0]     rd;

  // Load data arrives through the ALU's q path, so dm is not consumed here.
  logic           unused_dm;
  assign unused_dm = ^dm;

  assign rd     = ir_q[11:9];
  assign pa     = pc_q;
  assign k      = ir_q;
  assign x      = rf[ir_q[11:9]];
  assign y      = rf[ir_q[5:3]];
  assign cf     = cf_q;
  assign da     = ir_q[8:1];
  assign dw     = q;
  assign halted = (state_q == S_HALT);

  always_comb begin
    unique case (ir_q[11:10])
      2'b00:   take = 1'b1;
      2'b01:   take = zf_q;
      2'b10:   take = cf_q;
      default: take = ~zf_q;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value held over from a previous evaluation, which would infer a latch.
  always_comb begin
    state_d = state_q;
    rf_we   = 1'b0;
    cf_upd  = 1'b0;
    zf_upd  = 1'b0;
    pc_jump = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (!ir_q[15]) begin
          if (ir_q[14:12] < 3'd6) begin
            rf_we  = 1'b1;
            cf_upd = 1'b1;
            zf_upd = 1'b1;
          end
        end else begin
          case (ir_q[14:12])
            3'b000: begin
              if (ir_q[2:0] < 3'd6) begin
                rf_we  = 1'b1;
                cf_upd = 1'b1;
                zf_upd = 1'b1;
              end
            end
            3'b001: begin
              if (ir_q[2:0] < 3'd2) begin
                rf_we  = 1'b1;
                cf_upd = 1'b1;
                zf_upd = 1'b1;
              end else if (ir_q[2:0] == 3'd2) begin
                rf_we  = 1'b1;
                zf_upd = 1'b1;
              end
            end
            3'b010: begin
              if (ir_q[0]) we = 1'b1;
              else         state_d = S_MEM;
            end
            3'b011:  pc_jump = take;
            3'b111:  state_d = S_HALT;
            default: ;
          endcase
        end
      end
      // Load writeback: q carries dm here, carry is left alone.
      S_MEM: begin
        rf_we   = 1'b1;
        zf_upd  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        ir_q <= pd;
        pc_q <= pc_q + PAW'(1);
      end
      if (pc_jump) pc_q <= PAW'(ir_q[7:0]);
      if (cf_upd)  cf_q <= cl;
      if (zf_upd)  zf_q <= zl;
    end
  end

  // NOTE: the register file is only eight bytes of flops and must read as zero
  // after reset, so it is reset like any other state rather than left as RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (rf_we) begin
      rf[rd] <= q;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: an instruction-level reference model runs in
// lockstep with the DUT, with a stand-in ALU and program/data memories.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pa, x, y, q, da, dm, dw;
  logic [15:0] pd, k;
  logic        cf, cl, zl, we, halted;

  logic [15:0] prog   [256];
  logic [7:0]  dmem   [256];
  logic [7:0]  dmem_m [256];
  logic        sync_mem = 1'b0;

  logic [7:0]  r_m [8];
  logic        cf_m, zf_m;
  logic [7:0]  pc_m;
  logic [7:0]  last_dw;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .pa(pa), .pd(pd), .k(k), .x(x), .y(y), .cf(cf),
    .q(q), .cl(cl), .zl(zl), .da(da), .dm(dm), .dw(dw), .we(we), .halted(halted)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; cl is forced to 1 on results whose carry must be ignored.
  function automatic logic [8:0] alu_fn(input logic [15:0] kw, input logic [7:0] xa,
                                        input logic [7:0] ya, input logic [7:0] dma,
                                        input logic ci);
    logic [8:0] r;
    case (kw[15:12])
      4'h0:             r = {1'b0, kw[7:0]};
      4'h1, 4'h4, 4'h5: r = {1'b0, xa} + {1'b0, kw[7:0]};
      4'h2:             r = {1'b0, xa} + {1'b0, kw[7:0]} + {8'h00, ci};
      4'h3:             r = {1'b0, xa ^ kw[7:0]};
      4'h8:             r = {1'b0, xa} + {1'b0, ya} + {8'h00, ci};
      4'h9: begin
        case (kw[2:0])
          3'd0:    r = {1'b0, xa} + {1'b0, ya};
          3'd1:    r = {1'b0, xa} - {1'b0, ya};
          3'd2:    r = {1'b1, xa | ya};
          default: r = {1'b1, ~xa};
        endcase
      end
      4'hA:             r = kw[0] ? {1'b0, xa} : {1'b0, dma};
      default:          r = {1'b1, ~xa};
    endcase
    return r;
  endfunction

  assign {cl, q} = alu_fn(k, x, y, dm, cf);
  assign zl      = (q == 8'h00);

  always @(posedge clk) pd <= prog[pa];

  always @(posedge clk) begin
    if (sync_mem) dmem <= dmem_m;
    else if (we)  dmem[da] <= dw;
    dm <= dmem[da];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = 16'hF000;
  endtask

  // Holds reset for two cycles, checks reset outputs, releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) r_m[i] = 8'h00;
    cf_m = 1'b0;
    zf_m = 1'b0;
    pc_m = 8'h00;
    last_dw = 8'hEE;
    sync_mem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sync_mem = 1'b0;
    check("rst_pa", pa, 16'h0000);
    check("rst_k", k, 16'h0000);
    check("rst_we", we, 16'h0000);
    check("rst_halted", halted, 16'h0000);
    check("rst_cf", cf, 16'h0000);
    rst_n = 1'b1;
  endtask

  // Runs up to max_instr instructions starting in FETCH, comparing every cycle
  // of interest against the instruction-level model.
  task automatic run(input int max_instr);
    logic [15:0] ins;
    logic [2:0]  d, s;
    logic [8:0]  r;
    logic        is_st, is_ld, take;
    bit          done = 1'b0;
    for (int i = 0; i < max_instr && !done; i++) begin
      check("fetch_pa", pa, pc_m);
      check("flag_cf", cf, cf_m);
      check("not_halted", halted, 16'h0000);
      @(posedge clk); @(negedge clk);
      check("decode_we", we, 16'h0000);
      @(posedge clk); @(negedge clk);
      ins   = prog[pc_m];
      d     = ins[11:9];
      s     = ins[5:3];
      is_st = (ins[15:12] == 4'hA) && ins[0];
      is_ld = (ins[15:12] == 4'hA) && !ins[0];
      check("exec_k", k, ins);
      check("exec_x", x, r_m[d]);
      check("exec_y", y, r_m[s]);
      check("exec_we", we, {15'd0, is_st});
      pc_m = pc_m + 8'd1;
      r = alu_fn(ins, r_m[d], r_m[s], 8'h00, cf_m);
      if (is_st) begin
        check("st_da", da, ins[8:1]);
        check("st_dw", dw, r_m[d]);
        last_dw = dw;
        dmem_m[ins[8:1]] = r_m[d];
      end
      if ((!ins[15] && ins[14:12] < 3'd6) || (ins[15:12] == 4'h8 && ins[2:0] < 3'd6) ||
          (ins[15:12] == 4'h9 && ins[2:0] < 3'd2)) begin
        r_m[d] = r[7:0];
        cf_m   = r[8];
        zf_m   = (r[7:0] == 8'h00);
      end else if (ins[15:12] == 4'h9 && ins[2:0] == 3'd2) begin
        r_m[d] = r[7:0];
        zf_m   = (r[7:0] == 8'h00);
      end else if (ins[15:12] == 4'hB) begin
        case (ins[11:10])
          2'b00:   take = 1'b1;
          2'b01:   take = zf_m;
          2'b10:   take = cf_m;
          default: take = !zf_m;
        endcase
        if (take) pc_m = ins[7:0];
      end
      if (ins[15:12] == 4'hF) begin
        @(posedge clk); @(negedge clk);
        check("halt_flag", halted, 16'h0001);
        check("halt_we", we, 16'h0000);
        repeat (3) begin
          @(negedge clk);
          check("halt_pa_held", pa, pc_m);
          check("halt_stays", halted, 16'h0001);
        end
        done = 1'b1;
      end else begin
        if (is_ld) begin
          @(posedge clk); @(negedge clk);
          check("mem_we", we, 16'h0000);
          r_m[d] = dmem_m[ins[8:1]];
          zf_m   = (dmem_m[ins[8:1]] == 8'h00);
        end
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) dmem_m[a] = 8'h00;
    @(negedge clk);

    // Immediate op, store readback, halt after 3-cycle instructions.
    clear_prog();
    prog[0] = 16'h1205; prog[1] = 16'hA201; prog[2] = 16'hF000;
    do_reset();
    run(5);
    check("t1_r1", last_dw, 16'h0005);

    // Carry/zero from 0xFF+1, then add-with-carry.
    clear_prog();
    prog[0] = 16'h04FF; prog[1] = 16'h1401; prog[2] = 16'h2400;
    prog[3] = 16'hA401; prog[4] = 16'hF000;
    do_reset();
    run(8);
    check("t2_r2", last_dw, 16'h0001);

    // Store then load round trip through data memory.
    clear_prog();
    prog[0] = 16'h065A; prog[1] = 16'hA609; prog[2] = 16'hA808;
    prog[3] = 16'hA801; prog[4] = 16'hF000;
    do_reset();
    run(8);
    check("t3_r4", last_dw, 16'h005A);
    check("t3_mem4", dmem[4], 16'h005A);

    // Conditional jumps and PC wrap from 0xFF to 0x00.
    clear_prog();
    prog[8'h00] = 16'h0000; prog[8'h01] = 16'hB410;
    prog[8'h10] = 16'h0001; prog[8'h11] = 16'hB420; prog[8'h12] = 16'hB0FF;
    prog[8'hFF] = 16'h0203;
    do_reset();
    run(7);

    // Reset asserted in the EXEC cycle of a load aborts it cleanly.
    clear_prog();
    prog[0] = 16'hA808;
    dmem_m[4] = 8'h77;
    do_reset();
    @(posedge clk); @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pa", pa, 16'h0000);
    check("abort_we", we, 16'h0000);
    check("abort_k", k, 16'h0000);
    clear_prog();
    prog[0] = 16'hA801; prog[1] = 16'hF000;
    do_reset();
    run(4);
    check("abort_r4", last_dw, 16'h0000);

    // Unused encodings leave registers and flags alone.
    clear_prog();
    prog[0] = 16'h02C8; prog[1] = 16'h12C8; prog[2] = 16'h6000; prog[3] = 16'h8007;
    prog[4] = 16'h9003; prog[5] = 16'hC000; prog[6] = 16'hA201; prog[7] = 16'hF000;
    do_reset();
    run(10);
    check("t6_r1", last_dw, 16'h0090);

    // Random programs with random data memory, no halts.
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 256; a++) begin
        logic [31:0] w;
        w = $urandom;
        if (w[15:12] == 4'hF) w[15:12] = 4'h1;
        prog[a]   = w[15:0];
        dmem_m[a] = 8'($urandom);
      end
      do_reset();
      run(150);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
